// File: rtl/ddc_edid_pkg.sv
// rtl/ddc_edid_pkg.sv - shared types, default addresses and HPD timing helper for the EDID sink
package ddc_edid_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WOFS,
      WOFS_ACK,
      WSEG,
      WSEG_ACK,
      RD_BYTE,
      RD_ACK,
      WAIT_STOP
   } ddc_state_e;

   // Which transfer follows the address acknowledge.
   typedef enum logic [1:0] {
      TGT_WOFS,
      TGT_RD,
      TGT_WSEG
   } ddc_tgt_e;

   localparam logic [6:0] DDC_DEV_ADDR = 7'h50;
   localparam logic [6:0] DDC_SEG_ADDR = 7'h30;

   function automatic int unsigned hpd_cycles(input int unsigned clk_hz, input int unsigned low_ms);
      return clk_hz / 1000 * low_ms;
   endfunction

endpackage

// File: rtl/ddc_edid_seg_slave_if.sv
// rtl/ddc_edid_seg_slave_if.sv - DDC pad signals and EDID memory port bundle
interface ddc_edid_seg_slave_if #(
   parameter int MODE_W = 4,
   parameter int SEG_W  = 1
);
   logic                      i_scl;
   logic                      i_sda;
   logic                      o_sda_oe;
   logic [MODE_W+SEG_W+7:0]   o_mem_addr;
   logic [7:0]                i_mem_data;

   modport slave  (input  i_scl, i_sda, i_mem_data, output o_sda_oe, o_mem_addr);
   modport master (output i_scl, i_sda, i_mem_data, input  o_sda_oe, o_mem_addr);
endinterface

// File: rtl/i2c_in_filter.sv
// rtl/i2c_in_filter.sv - SCL/SDA synchroniser, glitch filter, edge and START/STOP detection
module i2c_in_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic i_local_clk,
   input  logic i_rst_n,
   input  logic scl,
   input  logic sda,
   output logic sda_f,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);
   localparam int CW = $clog2(FILT_LEN + 1);

   // Bit 1 carries SCL, bit 0 carries SDA; both idle high on the bus.
   logic [1:0]          raw;
   logic [1:0]          s1;
   logic [1:0]          s2;
   logic [1:0]          filt;
   logic [1:0]          prev;
   logic [1:0][CW-1:0]  cnt;

   assign raw = {scl, sda};

   always_ff @(posedge i_local_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1   <= 2'b11;
         s2   <= 2'b11;
         filt <= 2'b11;
         prev <= 2'b11;
         cnt  <= '0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         prev <= filt;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(FILT_LEN - 1)) begin
               filt[i] <= s2[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign sda_f     = filt[0];
   assign scl_rise  =  filt[1] & ~prev[1];
   assign scl_fall  = ~filt[1] &  prev[1];
   assign start_det =  prev[0] & ~filt[0] & filt[1];
   assign stop_det  = ~prev[0] &  filt[0] & filt[1];

endmodule

// File: rtl/ddc_edid_seg_slave.sv
// rtl/ddc_edid_seg_slave.sv - E-DDC EDID slave serving segmented images per mode, with HPD pulsing on mode change
module ddc_edid_seg_slave
   import ddc_edid_pkg::*;
#(
   parameter int          MODE_W     = 4,
   parameter int          SEG_W      = 1,
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned HPD_LOW_MS = 100,
   parameter int          FILT_LEN   = 3,
   parameter logic [6:0]  DEV_ADDR   = DDC_DEV_ADDR,
   parameter logic [6:0]  SEG_ADDR   = DDC_SEG_ADDR
) (
   input  logic                 i_local_clk,
   input  logic                 i_rst_n,
   input  logic [MODE_W-1:0]    i_mode,
   ddc_edid_seg_slave_if.slave  bus,
   output logic                 o_hpd,
   output logic                 o_busy
);
   localparam int unsigned HPD_CYC  = hpd_cycles(CLK_HZ, HPD_LOW_MS);
   localparam int          HC_W     = $clog2(HPD_CYC + 1) + 1;
   localparam logic [8:0]  SEG_LIM  = 9'(1 << SEG_W);

   logic sda_f, scl_rise, scl_fall, start_det, stop_det;

   i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_filt (
      .i_local_clk (i_local_clk),
      .i_rst_n     (i_rst_n),
      .scl         (bus.i_scl),
      .sda         (bus.i_sda),
      .sda_f       (sda_f),
      .scl_rise    (scl_rise),
      .scl_fall    (scl_fall),
      .start_det   (start_det),
      .stop_det    (stop_det)
   );

   ddc_state_e          state, state_n;
   ddc_tgt_e            tgt, tgt_n;
   logic [7:0]          sh, sh_n;
   logic [3:0]          bit_cnt, bit_cnt_n;
   logic                mack, mack_n;
   logic                sda_oe, sda_oe_n;
   logic [7:0]          offset, offset_n;
   logic [SEG_W-1:0]    seg_q, seg_n;
   logic                busy_n;
   logic [MODE_W-1:0]   mode_q, mode_s1, mode_s2;
   logic [HC_W-1:0]     hpd_cnt;

   assign bus.o_mem_addr = {mode_q, seg_q, offset};
   assign bus.o_sda_oe   = sda_oe;

   always_ff @(posedge i_local_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         tgt     <= TGT_WOFS;
         sh      <= '0;
         bit_cnt <= '0;
         mack    <= 1'b0;
         sda_oe  <= 1'b0;
         offset  <= '0;
         seg_q   <= '0;
         o_busy  <= 1'b0;
      end else begin
         state   <= state_n;
         tgt     <= tgt_n;
         sh      <= sh_n;
         bit_cnt <= bit_cnt_n;
         mack    <= mack_n;
         sda_oe  <= sda_oe_n;
         offset  <= offset_n;
         seg_q   <= seg_n;
         o_busy  <= busy_n;
      end
   end

   always_comb begin
      state_n   = state;
      tgt_n     = tgt;
      sh_n      = sh;
      bit_cnt_n = bit_cnt;
      mack_n    = mack;
      sda_oe_n  = sda_oe;
      offset_n  = offset;
      seg_n     = seg_q;
      busy_n    = o_busy;

      if (stop_det) begin
         state_n  = IDLE;
         seg_n    = '0;
         busy_n   = 1'b0;
         sda_oe_n = 1'b0;
      end else if (start_det) begin
         // Repeated START keeps seg_q so the E-DDC segment write applies to the next read.
         state_n   = ADDR;
         bit_cnt_n = '0;
         sda_oe_n  = 1'b0;
      end else begin
         unique case (state)
            ADDR: begin
               if (scl_rise && bit_cnt < 4'd8) begin
                  sh_n      = {sh[6:0], sda_f};
                  bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  bit_cnt_n = '0;
                  state_n   = ADDR_ACK;
                  sda_oe_n  = 1'b1;
                  busy_n    = 1'b1;
                  if (sh == {DEV_ADDR, 1'b0}) begin
                     tgt_n = TGT_WOFS;
                  end else if (sh == {DEV_ADDR, 1'b1}) begin
                     tgt_n = TGT_RD;
                  end else if (sh == {SEG_ADDR, 1'b0}) begin
                     tgt_n = TGT_WSEG;
                  end else begin
                     state_n  = WAIT_STOP;
                     sda_oe_n = 1'b0;
                     busy_n   = o_busy;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_n = '0;
                  if (tgt == TGT_RD) begin
                     sh_n     = bus.i_mem_data;
                     sda_oe_n = ~bus.i_mem_data[7];
                     offset_n = offset + 8'd1;
                     state_n  = RD_BYTE;
                  end else begin
                     sda_oe_n = 1'b0;
                     state_n  = (tgt == TGT_WSEG) ? WSEG : WOFS;
                  end
               end
            end
            WOFS, WSEG: begin
               if (scl_rise && bit_cnt < 4'd8) begin
                  sh_n      = {sh[6:0], sda_f};
                  bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  bit_cnt_n = '0;
                  if (state == WOFS) begin
                     offset_n = sh;
                     sda_oe_n = 1'b1;
                     state_n  = WOFS_ACK;
                  end else if ({1'b0, sh} < SEG_LIM) begin
                     seg_n    = sh[SEG_W-1:0];
                     sda_oe_n = 1'b1;
                     state_n  = WSEG_ACK;
                  end else begin
                     state_n  = WAIT_STOP;
                  end
               end
            end
            WOFS_ACK, WSEG_ACK: begin
               // Later write bytes land in WAIT_STOP and go unacknowledged: the image is read-only.
               if (scl_fall) begin
                  sda_oe_n = 1'b0;
                  state_n  = WAIT_STOP;
               end
            end
            RD_BYTE: begin
               if (scl_rise && bit_cnt < 4'd8) begin
                  bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  bit_cnt_n = '0;
                  sda_oe_n  = 1'b0;
                  mack_n    = 1'b0;
                  state_n   = RD_ACK;
               end else if (scl_fall && bit_cnt != 4'd0) begin
                  sh_n     = {sh[6:0], 1'b0};
                  sda_oe_n = ~sh[6];
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  mack_n = ~sda_f;
               end else if (scl_fall) begin
                  if (mack) begin
                     sh_n     = bus.i_mem_data;
                     sda_oe_n = ~bus.i_mem_data[7];
                     offset_n = offset + 8'd1;
                     state_n  = RD_BYTE;
                  end else begin
                     sda_oe_n = 1'b0;
                     state_n  = WAIT_STOP;
                  end
               end
            end
            IDLE, WAIT_STOP: begin
               sda_oe_n = 1'b0;
            end
            default: begin
               state_n  = IDLE;
               sda_oe_n = 1'b0;
            end
         endcase
      end
   end

   // Mode changes wait for the bus to go idle so an image is never swapped under a read.
   always_ff @(posedge i_local_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mode_s1 <= '0;
         mode_s2 <= '0;
         mode_q  <= '0;
         o_hpd   <= 1'b0;
         hpd_cnt <= '0;
      end else begin
         mode_s1 <= i_mode;
         mode_s2 <= mode_s1;
         if (mode_s2 != mode_q && !o_busy) begin
            mode_q  <= mode_s2;
            o_hpd   <= 1'b0;
            hpd_cnt <= '0;
         end else if (hpd_cnt == HC_W'(HPD_CYC - 1)) begin
            o_hpd   <= 1'b1;
         end else begin
            hpd_cnt <= hpd_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ddc_edid_seg_slave.sv
// tb/tb_ddc_edid_seg_slave.sv - directed bench for the EDID segment slave
module tb_ddc_edid_seg_slave;
   localparam int Q    = 10;
   localparam int FILT = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] mode = 4'd0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       hpd, busy;
   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         oe_cnt = 0;
   int         hpd_fall_cyc = 0;
   logic       hpd_prev = 1'b0;

   ddc_edid_seg_slave_if #(.MODE_W(4), .SEG_W(1)) bus();

   assign bus.i_scl = scl_m;
   assign bus.i_sda = sda_m & ~bus.o_sda_oe;

   ddc_edid_seg_slave #(
      .MODE_W(4), .SEG_W(1), .CLK_HZ(1000), .HPD_LOW_MS(5), .FILT_LEN(FILT),
      .DEV_ADDR(7'h50), .SEG_ADDR(7'h30)
   ) dut (
      .i_local_clk (clk),
      .i_rst_n     (rst_n),
      .i_mode      (mode),
      .bus         (bus),
      .o_hpd       (hpd),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_byte(input logic [12:0] a);
      return a[7:0] ^ {a[12:9], a[8], 3'b000};
   endfunction

   always @(posedge clk) bus.i_mem_data <= rom_byte(bus.o_mem_addr);

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.o_sda_oe) oe_cnt = oe_cnt + 1;
      if (hpd_prev && !hpd) hpd_fall_cyc = cyc;
      hpd_prev = hpd;
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic i2c_start;
      sda_m = 1'b1; clks(Q);
      scl_m = 1'b1; clks(Q);
      sda_m = 1'b0; clks(Q);
      scl_m = 1'b0; clks(Q);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0; clks(Q);
      scl_m = 1'b1; clks(Q);
      sda_m = 1'b1; clks(Q);
   endtask

   task automatic i2c_bit(input logic b, output logic s, input logic glitch);
      sda_m = b;
      if (glitch) begin
         clks(Q / 2);
         scl_m = 1'b1; clks(FILT - 1);
         scl_m = 1'b0; clks(Q - Q / 2 - (FILT - 1));
      end else begin
         clks(Q);
      end
      scl_m = 1'b1; clks(Q);
      s = bus.i_sda;
      clks(Q);
      scl_m = 1'b0; clks(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack, input int glitch_bit);
      logic s;
      for (int i = 7; i >= 0; i--) i2c_bit(b[i], s, i == glitch_bit);
      i2c_bit(1'b1, s, 1'b0);
      ack = ~s;
   endtask

   task automatic rd_byte(output logic [7:0] d, input logic mack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         i2c_bit(1'b1, s, 1'b0);
         d[i] = s;
      end
      i2c_bit(~mack, s, 1'b0);
   endtask

   task automatic set_ofs_rd(input logic [7:0] ofs, input string tag);
      logic ack;
      i2c_start;
      wr_byte(8'hA0, ack, -1); check({tag, "_ack_a0"}, ack, 1);
      wr_byte(ofs,   ack, -1); check({tag, "_ack_ofs"}, ack, 1);
      i2c_start;
      wr_byte(8'hA1, ack, -1); check({tag, "_ack_a1"}, ack, 1);
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      int         oe_before;
      int         stop_cyc;

      clks(3);
      check("rst_oe",   bus.o_sda_oe, 0);
      check("rst_hpd",  hpd, 0);
      check("rst_busy", busy, 0);
      check("rst_addr", bus.o_mem_addr, 0);
      rst_n = 1'b1;
      clks(4); check("hpd_rst_early", hpd, 0);
      clks(1); check("hpd_rst_rise", hpd, 1);

      // Sequential read from offset 0
      set_ofs_rd(8'h00, "seq");
      check("seq_busy", busy, 1);
      for (int k = 0; k < 8; k++) begin
         rd_byte(d, k < 7);
         check($sformatf("seq_d%0d", k), d, k);
      end
      i2c_stop;
      check("seq_busy_stop", busy, 0);

      // E-DDC segment 1 read
      i2c_start;
      wr_byte(8'h60, ack, -1); check("seg_ack_60", ack, 1);
      wr_byte(8'h01, ack, -1); check("seg_ack_01", ack, 1);
      i2c_start;
      wr_byte(8'hA0, ack, -1); check("seg_ack_a0", ack, 1);
      wr_byte(8'h80, ack, -1); check("seg_ack_80", ack, 1);
      check("seg_addr80", bus.o_mem_addr, 13'h180);
      i2c_start;
      wr_byte(8'hA1, ack, -1); check("seg_ack_a1", ack, 1);
      check("seg_addr81", bus.o_mem_addr, 13'h181);
      rd_byte(d, 1'b1); check("seg_d0", d, 8'h88);
      rd_byte(d, 1'b0); check("seg_d1", d, 8'h89);
      i2c_stop;
      set_ofs_rd(8'h00, "seg0");
      check("seg0_addr", bus.o_mem_addr, 13'h001);
      rd_byte(d, 1'b0); check("seg0_d", d, 8'h00);
      i2c_stop;

      // Segment pointer out of range
      i2c_start;
      wr_byte(8'h60, ack, -1); check("oor_ack_60", ack, 1);
      wr_byte(8'h02, ack, -1); check("oor_nack_02", ack, 0);
      set_ofs_rd(8'h10, "oor");
      rd_byte(d, 1'b0); check("oor_d", d, 8'h10);
      i2c_stop;

      // Offset wrap
      set_ofs_rd(8'hFF, "wrap");
      rd_byte(d, 1'b1); check("wrap_dff", d, 8'hFF);
      rd_byte(d, 1'b0); check("wrap_d00", d, 8'h00);
      i2c_stop;

      // Foreign addresses
      oe_before = oe_cnt;
      i2c_start;
      wr_byte(8'hA2, ack, -1); check("for_nack_a2", ack, 0);
      wr_byte(8'h55, ack, -1);
      i2c_start;
      wr_byte(8'h61, ack, -1); check("for_nack_61", ack, 0);
      i2c_stop;
      check("for_oe_quiet", oe_cnt - oe_before, 0);
      check("for_busy", busy, 0);

      // SCL glitch inside the offset byte
      i2c_start;
      wr_byte(8'hA0, ack, -1); check("gl_ack_a0", ack, 1);
      wr_byte(8'h05, ack, 3);  check("gl_ack_ofs", ack, 1);
      i2c_start;
      wr_byte(8'hA1, ack, -1); check("gl_ack_a1", ack, 1);
      rd_byte(d, 1'b0); check("gl_d", d, 8'h05);
      i2c_stop;

      // Idle mode change 0 -> 3
      mode = 4'd3;
      clks(2); check("mc_hpd_pre", hpd, 1);
      clks(1); check("mc_hpd_drop", hpd, 0);
      check("mc_mode", bus.o_mem_addr[12:9], 3);
      clks(4); check("mc_hpd_low", hpd, 0);
      clks(1); check("mc_hpd_rise", hpd, 1);

      // Mode change during a read is deferred until STOP
      set_ofs_rd(8'h00, "def");
      mode = 4'd5;
      rd_byte(d, 1'b1); check("def_d0", d, 8'h30); check("def_hpd0", hpd, 1);
      rd_byte(d, 1'b0); check("def_d1", d, 8'h31); check("def_hpd1", hpd, 1);
      check("def_mode_held", bus.o_mem_addr[12:9], 3);
      stop_cyc = cyc;
      i2c_stop;
      clks(10);
      check("def_hpd_after_stop", (hpd_fall_cyc > stop_cyc) ? 1 : 0, 1);
      check("def_mode_new", bus.o_mem_addr[12:9], 5);
      check("def_hpd_back", hpd, 1);

      // Asynchronous reset while the slave drives SDA
      set_ofs_rd(8'h00, "ar");
      check("ar_oe_driving", bus.o_sda_oe, 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_oe", bus.o_sda_oe, 0);
      check("ar_busy", busy, 0);
      check("ar_hpd", hpd, 0);
      scl_m = 1'b1;
      sda_m = 1'b1;
      clks(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ddc_edid_seg_slave.md
Name: ddc_edid_seg_slave

Overview:
- Parametrised E-DDC/EDID sink for HDMI/DVI receive paths, with the I2C slave FSM built in.
- Serves multi-segment EDID images (segment pointer at 0x30, data at 0x50) from an external synchronous ROM/RAM, with one image per video mode.
- Drives HPD low for a programmable time whenever the selected mode changes, so the source re-reads the EDID.

Parameters:
- MODE_W, 4: width of the mode select; there are 2^MODE_W EDID images.
- SEG_W, 1: segment-pointer width; 2^SEG_W segments of 256 bytes per image.
- CLK_HZ, 50_000_000: i_local_clk frequency in Hz.
- HPD_LOW_MS, 100: HPD deassert time in ms. HPD_CYC = CLK_HZ/1000*HPD_LOW_MS.
- FILT_LEN, 3: SCL/SDA glitch filter; a level must be stable this many clocks to be accepted.
- DEV_ADDR, 7'h50: EDID data slave address.
- SEG_ADDR, 7'h30: segment-pointer slave address.

Ports:
- i_local_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_mode  in  MODE_W  requested EDID image; asynchronous-safe, quasi-static.
- o_mem_addr  out  MODE_W+SEG_W+8  {mode_q, seg_q, offset}.
- i_mem_data  in  8  ROM data, valid 1 clock after o_mem_addr.
- i_scl  in  1  DDC SCL.
- i_sda  in  1  DDC SDA, pad input.
- o_sda_oe  out  1  1 = pull SDA low; the top level builds the open-drain pad.
- o_hpd  out  1  hot-plug detect.
- o_busy  out  1  high from START to STOP when this slave is addressed.

Behaviour:
- Clocking and reset: one clock, i_local_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: o_sda_oe=0, o_hpd=0, o_busy=0, seg_q=0, offset=0, mode_q=0, FSM=IDLE. The HPD counter starts at 0.
- Input conditioning:
  - SCL and SDA each pass a 2-flop synchroniser and then the FILT_LEN filter.
  - Edges are detected on the filtered signals.
  - START/repeated START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Both are recognised in every state and take priority.
- Bit sampling and driving:
  - Data is sampled on the filtered SCL rising edge.
  - o_sda_oe changes only on the SCL falling edge, at least 1 clock after it.
- FSM states: IDLE, ADDR, ADDR_ACK, WOFS, WOFS_ACK, WSEG, WSEG_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- IDLE -> ADDR on START.
- ADDR shifts in 8 bits, MSB first.
  - {DEV_ADDR,0} -> ack -> WOFS.
  - {DEV_ADDR,1} -> ack -> RD_BYTE.
  - {SEG_ADDR,0} -> ack -> WSEG.
  - Any other address, including {SEG_ADDR,1}: no ack (SDA released), -> WAIT_STOP.
- WOFS: the byte loads offset; ack; -> WAIT_STOP-like ignore state. Further write bytes to DEV_ADDR are NACKed because the EDID is read-only.
- WSEG:
  - If byte < 2^SEG_W: seg_q = byte[SEG_W-1:0], ack.
  - Otherwise: NACK, seg_q unchanged.
  - Then -> WAIT_STOP.
- RD_BYTE:
  - At ADDR_ACK end and after each master ACK, the shift register loads i_mem_data for address {mode_q,seg_q,offset}.
  - o_mem_addr is presented at least 2 clocks before the SCL fall that shifts out the MSB.
  - offset increments (8-bit, wraps 0xFF->0x00; segment does not change).
- RD_ACK:
  - Master ACK (SDA=0) -> RD_BYTE.
  - Master NACK -> WAIT_STOP.
- WAIT_STOP: SDA released; waits for START or STOP.
- Segment-pointer lifetime:
  - seg_q is cleared to 0 on every STOP.
  - seg_q is preserved across repeated START (E-DDC sequence).
  - A START after STOP begins with seg_q=0.
- o_busy: set at address match, cleared at STOP.
- Mode/HPD control:
  - i_mode is synchronised by 2 flops.
  - When the synchronised value differs from mode_q:
    - A value ≥ 2^MODE_W cannot occur; no clamp is needed.
    - The change is held pending while o_busy=1.
    - When o_busy=0: mode_q takes the new value, o_hpd drops the same cycle, and the counter clears.
  - o_hpd=1 after the counter reaches HPD_CYC-1; the counter then saturates.
  - A mode change during the low period restarts the count.
  - After reset, o_hpd rises after HPD_CYC clocks.
- Reset mid-transaction: all state returns to reset values immediately; SDA is released within the same cycle (asynchronous).

Decomposition:
- Package ddc_edid_pkg holds:
  - FSM state enum.
  - Default addresses 7'h50 and 7'h30.
  - Helper function for HPD_CYC.
- Sub-module i2c_in_filter: synchroniser, glitch filter and edge/START/STOP detect. Instantiated once and covers both lines.
- FSM, address generation and HPD logic live in the top module.

Test Plan:
- Sequential read: mode=0, ROM[i]=i. START, 0xA0, 0x00, rSTART, 0xA1, read 8 bytes, NACK, STOP -> data 0x00..0x07, all ACKs driven, o_busy 1→0 at STOP.
- E-DDC segment read: SEG_W=1, START, 0x60, 0x01, rSTART, 0xA0, 0x80, rSTART, 0xA1, read 2 bytes -> o_mem_addr = {0,1,0x80} and {0,1,0x81}. After STOP, a plain read at offset 0 returns segment 0.
- Segment out of range: write 0x60, 0x02 -> data byte NACKed, seg_q stays 0.
- Wrap and foreign address:
  - Set offset 0xFF, read 2 bytes -> ROM[0xFF] then ROM[0x00].
  - Address 0xA2 -> no ACK, o_sda_oe stays 0 until STOP.
- HPD:
  - CLK_HZ=1000, HPD_LOW_MS=5 -> o_hpd rises 5 clocks after reset.
  - Change i_mode 0→3 -> o_hpd low 5 clocks and mode_q=3.
  - Change during an active read -> HPD drop deferred until after STOP.
- Glitch: SCL pulse of FILT_LEN-1 clocks mid-byte -> ignored, received byte unchanged.
